// File: rtl/jpeg_bit_buffer_pkg.sv
// jpeg_bit_buffer_pkg: shared widths, JPEG byte constants and append-length encoding
package jpeg_bit_buffer_pkg;
  localparam int BUF_W_DEF = 128;
  localparam int CNT_W_DEF = 8;
  localparam logic [7:0] MARKER_BYTE = 8'hFF;
  localparam logic [7:0] STUFF_BYTE = 8'h00;
  typedef enum logic [4:0] {APP_NONE = 5'd0, APP_BYTE = 5'd8, APP_WORD = 5'd16} app_len_e;
endpackage

// File: rtl/jpeg_bit_buffer_if.sv
// jpeg_bit_buffer_if: byte stream handshake into the bit buffer
interface jpeg_bit_buffer_if;
  logic in_valid;
  logic [7:0] in_data;
  logic in_last;
  logic in_ready;
  modport master(output in_valid, in_data, in_last, input in_ready);
  modport slave(input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/jpeg_destuff.sv
// jpeg_destuff: removes 0xFF00 stuffing and reports markers, holding a pending 0xFF
module jpeg_destuff
  import jpeg_bit_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic [7:0] in_byte,
  input  logic valid,
  input  logic destuff_en,
  input  logic eof,
  output logic [15:0] append_data,
  output app_len_e append_len,
  output logic stuff_pulse,
  output logic marker_pulse,
  output logic ff_pend
);
  logic is_ff, is_00, pend_next;
  assign is_ff = in_byte == MARKER_BYTE;
  assign is_00 = in_byte == STUFF_BYTE;
  // turn an accepted byte, or a stranded 0xFF at end of stream/decode, into left-aligned bits
  always_comb begin
    append_data = '0;
    append_len = APP_NONE;
    stuff_pulse = 1'b0;
    marker_pulse = 1'b0;
    pend_next = ff_pend;
    if (valid && !destuff_en) begin
      append_data = ff_pend ? {MARKER_BYTE, in_byte} : {in_byte, 8'h00};
      append_len = ff_pend ? APP_WORD : APP_BYTE;
      pend_next = 1'b0;
    end else if (valid && ff_pend) begin
      append_data = {MARKER_BYTE, (is_00 || is_ff) ? 8'h00 : in_byte};
      append_len = (is_00 || is_ff) ? APP_BYTE : APP_WORD;
      stuff_pulse = is_00;
      marker_pulse = !is_00 && !is_ff;
      pend_next = is_ff;
    end else if (valid) begin
      append_data = is_ff ? 16'h0000 : {in_byte, 8'h00};
      append_len = is_ff ? APP_NONE : APP_BYTE;
      pend_next = is_ff;
    end else if (ff_pend && (eof || !destuff_en)) begin
      append_data = {MARKER_BYTE, 8'h00};
      append_len = APP_BYTE;
      pend_next = 1'b0;
    end
  end
  // pending 0xFF flag
  always_ff @(posedge clk)
    ff_pend <= (rst || clear) ? 1'b0 : pend_next;
endmodule

// File: rtl/jpeg_bit_buffer.sv
// jpeg_bit_buffer: destuffed JPEG byte stream to a 64-bit MSB-aligned bit window
module jpeg_bit_buffer
  import jpeg_bit_buffer_pkg::*;
#(
  parameter int BUF_W = BUF_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  jpeg_bit_buffer_if.slave in_if,
  input  logic destuff_en,
  input  logic eat_en,
  input  logic [6:0] eat_num,
  input  logic align_req,
  input  logic clear,
  output logic bit_avali,
  output logic [63:0] bit_out,
  output logic marker_seen,
  output logic [15:0] stuff_cnt
);
  logic [BUF_W-1:0] shreg, shreg_next;
  logic [CNT_W-1:0] fill, eat_amt, eaten, base;
  logic [2:0] bit_pos, align_n;
  logic eof_seen, accept, do_eat, do_align, ff_pend, stuff_pulse, marker_pulse;
  logic [15:0] append_data;
  app_len_e append_len;
  assign in_if.in_ready = (fill <= CNT_W'(BUF_W - 16)) && !clear && !rst && !eof_seen;
  assign accept = in_if.in_valid && in_if.in_ready;
  assign bit_avali = (fill >= CNT_W'(64)) || (eof_seen && fill != '0 && !ff_pend);
  assign bit_out = shreg[BUF_W-1 -: 64];
  assign do_eat = eat_en && bit_avali;
  assign do_align = align_req && bit_avali && !eat_en;
  assign align_n = ~bit_pos + 3'd1;
  assign eat_amt = do_eat ? CNT_W'(eat_num) : do_align ? CNT_W'(align_n) : '0;
  assign eaten = (eat_amt < fill) ? eat_amt : fill;
  assign base = fill - eaten;
  assign shreg_next = (shreg << eaten) | ({append_data, {(BUF_W-16){1'b0}}} >> base);
  jpeg_destuff u_destuff (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_byte(in_if.in_data),
    .valid(accept),
    .destuff_en(destuff_en),
    .eof(eof_seen),
    .append_data(append_data),
    .append_len(append_len),
    .stuff_pulse(stuff_pulse),
    .marker_pulse(marker_pulse),
    .ff_pend(ff_pend)
  );
  // consume from the top and append at the post-consume fill point in one step
  always_ff @(posedge clk)
    if (rst || clear) begin
      shreg <= '0;
      fill <= '0;
      bit_pos <= '0;
      eof_seen <= 1'b0;
      marker_seen <= 1'b0;
      stuff_cnt <= '0;
    end else begin
      shreg <= shreg_next;
      fill <= base + CNT_W'(append_len);
      bit_pos <= do_eat ? bit_pos + eat_num[2:0] : do_align ? 3'd0 : bit_pos;
      eof_seen <= eof_seen || (accept && in_if.in_last);
      marker_seen <= marker_seen || marker_pulse;
      stuff_cnt <= stuff_cnt + 16'(stuff_pulse && stuff_cnt != '1);
    end
endmodule

// File: tb/tb_jpeg_bit_buffer.sv
// tb_jpeg_bit_buffer: scoreboard bench comparing the bit window against a bit-queue model
module tb_jpeg_bit_buffer;
  import jpeg_bit_buffer_pkg::*;
  logic clk = 1'b0, rst = 1'b1, destuff_en = 1'b0, eat_en = 1'b0, align_req = 1'b0, clear = 1'b0;
  logic [6:0] eat_num = '0;
  logic bit_avali, marker_seen;
  logic [63:0] bit_out;
  logic [15:0] stuff_cnt;
  int checks = 0, errors = 0;
  bit q[$];
  bit m_pend, m_eof, m_marker, last_acc;
  int m_stuff, m_pos, max_fill;
  logic [7:0] t1[8] = '{8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00, 8'h43, 8'h00, 8'h01};
  logic [7:0] t2[9] = '{8'h12, 8'h34, 8'hFF, 8'h00, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
  jpeg_bit_buffer_if bus();
  jpeg_bit_buffer dut (
    .clk(clk),
    .rst(rst),
    .in_if(bus),
    .destuff_en(destuff_en),
    .eat_en(eat_en),
    .eat_num(eat_num),
    .align_req(align_req),
    .clear(clear),
    .bit_avali(bit_avali),
    .bit_out(bit_out),
    .marker_seen(marker_seen),
    .stuff_cnt(stuff_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (eat_en) assert (eat_num <= 7'd64) else $error("FAIL eat_num %0d exceeds 64", eat_num);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic m_reset;
    q.delete();
    m_pend = 0;
    m_eof = 0;
    m_marker = 0;
    m_stuff = 0;
    m_pos = 0;
  endtask
  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) q.push_back(b[i]);
  endtask
  task automatic pop_n(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) void'(q.pop_front());
  endtask
  function automatic logic [63:0] window();
    logic [63:0] w = '0;
    for (int i = 0; i < 64; i++) if (i < q.size()) w[63-i] = q[i];
    return w;
  endfunction
  function automatic bit m_avail();
    return q.size() >= 64 || (m_eof && q.size() > 0 && !m_pend);
  endfunction
  function automatic bit m_ready();
    return !rst && !clear && !m_eof && q.size() <= 112;
  endfunction
  task automatic model_byte(input logic [7:0] b);
    if (!destuff_en) begin
      if (m_pend) push_byte(8'hFF);
      m_pend = 0;
      push_byte(b);
    end else if (m_pend) begin
      push_byte(8'hFF);
      if (b == 8'h00) begin
        m_stuff++;
        m_pend = 0;
      end else if (b != 8'hFF) begin
        push_byte(b);
        m_marker = 1;
        m_pend = 0;
      end
    end else if (b == 8'hFF) m_pend = 1;
    else push_byte(b);
  endtask
  task automatic step;
    bit acc, av;
    logic [7:0] b;
    @(negedge clk);
    check("in_ready", bus.in_ready, m_ready());
    check("bit_avali", bit_avali, m_avail());
    acc = bus.in_valid && m_ready();
    av = m_avail();
    b = bus.in_data;
    @(posedge clk);
    last_acc = acc;
    if (rst || clear) m_reset();
    else begin
      if (eat_en && av) begin
        pop_n(eat_num);
        m_pos = (m_pos + eat_num) % 8;
      end else if (align_req && av) begin
        pop_n((8 - m_pos) % 8);
        m_pos = 0;
      end
      if (acc) begin
        model_byte(b);
        if (bus.in_last) m_eof = 1;
      end else if (m_pend && (m_eof || !destuff_en)) begin
        push_byte(8'hFF);
        m_pend = 0;
      end
    end
    if (q.size() > max_fill) max_fill = q.size();
    #1;
    check("bit_out", bit_out, window());
    check("fill", dut.fill, q.size());
    check("marker_seen", marker_seen, m_marker);
    check("stuff_cnt", stuff_cnt, m_stuff);
  endtask
  task automatic send(input logic [7:0] b, input logic last);
    bus.in_valid = 1;
    bus.in_data = b;
    bus.in_last = last;
    step;
    bus.in_valid = 0;
    bus.in_last = 0;
  endtask
  task automatic pulse_clear;
    clear = 1;
    step;
    clear = 0;
  endtask
  initial begin
    logic [7:0] cur;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_last = 0;
    m_reset();
    step;
    step;
    rst = 0;
    step;
    check("reset_out", bit_out, 64'h0);
    destuff_en = 0;
    for (int i = 0; i < 8; i++) begin
      send(t1[i], 0);
      if (i == 6) check("t1_early", bit_avali, 1'b0);
    end
    check("t1_avail", bit_avali, 1'b1);
    check("t1_window", bit_out, 64'hFFD8FFDB00430001);
    check("t1_stuff", stuff_cnt, 16'd0);
    pulse_clear;
    destuff_en = 1;
    for (int i = 0; i < 9; i++) send(t2[i], 0);
    check("t2_window", bit_out, 64'h1234FF56789ABCDE);
    check("t2_stuff", stuff_cnt, 16'd1);
    check("t2_marker", marker_seen, 1'b0);
    pulse_clear;
    destuff_en = 0;
    for (int i = 0; i < 9; i++) send(8'hA5, 0);
    eat_en = 1;
    eat_num = 3;
    step;
    eat_en = 0;
    align_req = 1;
    step;
    check("t3_pos", dut.bit_pos, 3'd0);
    check("t3_window", bit_out, 64'hA5A5A5A5A5A5A5A5);
    check("t3_fill", dut.fill, 8'd64);
    step;
    align_req = 0;
    check("t3_noop_fill", dut.fill, 8'd64);
    pulse_clear;
    destuff_en = 1;
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'hFF, 0);
    send(8'hD9, 1);
    check("t4_marker", marker_seen, 1'b1);
    check("t4_window", bit_out, 64'h1122FFD900000000);
    check("t4_ready", bus.in_ready, 1'b0);
    eat_en = 1;
    eat_num = 8;
    for (int i = 0; i < 10 && m_avail(); i++) step;
    eat_en = 0;
    check("t4_drained", bit_avali, 1'b0);
    check("t4_fill", dut.fill, 8'd0);
    pulse_clear;
    send(8'h33, 0);
    send(8'hFF, 1);
    check("t4_pend_avail", bit_avali, 1'b0);
    step;
    check("t4_flush", bit_out, 64'h33FF000000000000);
    check("t4_flush_avail", bit_avali, 1'b1);
    pulse_clear;
    send(8'h44, 0);
    send(8'hFF, 0);
    destuff_en = 0;
    step;
    check("t5_fall_flush", bit_out, 64'h44FF000000000000);
    pulse_clear;
    destuff_en = 1;
    eat_en = 1;
    eat_num = 7;
    max_fill = 0;
    cur = 8'h5A;
    bus.in_valid = 1;
    for (int i = 0; i < 400; i++) begin
      bus.in_data = cur;
      step;
      if (last_acc)
        cur = ($urandom_range(0, 7) == 0) ? 8'hFF : ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
    end
    bus.in_valid = 0;
    eat_en = 0;
    check("t6_max_fill", max_fill > 112 && max_fill <= 128, 1'b1);
    pulse_clear;
    send(8'hFF, 0);
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h12, 0);
    for (int i = 0; i < 9; i++) send(8'(8'h20 + i), 0);
    eat_en = 1;
    eat_num = 6;
    step;
    eat_en = 0;
    send(8'hFF, 0);
    check("t7_fill", dut.fill, 8'd90);
    check("t7_pend", dut.u_destuff.ff_pend, 1'b1);
    check("t7_marker", marker_seen, 1'b1);
    check("t7_stuff", stuff_cnt, 16'd1);
    pulse_clear;
    check("t7_clr_fill", dut.fill, 8'd0);
    check("t7_clr_avail", bit_avali, 1'b0);
    check("t7_clr_marker", marker_seen, 1'b0);
    check("t7_clr_stuff", stuff_cnt, 16'd0);
    check("t7_clr_out", bit_out, 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jpeg_bit_buffer.md
Name: jpeg_bit_buffer

Overview:
- Upstream feeder of the JPEG control FSM.
- Accepts the raw JPEG byte stream and presents a 64-bit MSB-aligned bit window (bit_out) plus its availability flag (bit_avali).
- Removes 0xFF00 byte stuffing while entropy-coded data is being decoded.
- Discards a variable number of consumed bits per cycle and supports byte re-alignment before markers.

Parameters:
- BUF_W, 128, internal shift-register width in bits; must be ≥ 64 + 16.
- CNT_W, 8, width of fill counter; holds 0..BUF_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_last  in  1  marks final byte of file; qualified by in_valid
- in_ready  out  1  byte accepted when in_valid & in_ready
- destuff_en  in  1  high while the FSM is in the entropy-decode state; enables 0xFF00 removal
- eat_en  in  1  consume request
- eat_num  in  7  bits to consume, 0..64
- align_req  in  1  pulse: discard bits up to the next byte boundary
- clear  in  1  pulse: empty buffer for next picture (FSM reset state)
- bit_avali  out  1  window valid
- bit_out  out  64  next 64 stream bits, bit 63 first
- marker_seen  out  1  sticky: 0xFF followed by non-0x00 seen while destuff_en
- stuff_cnt  out  16  count of removed 0x00 stuff bytes, saturating

Behaviour:
- Reset/clear: buffer zero, fill=0, bit_pos=0, eof_seen=0, ff_pend=0, marker_seen=0, stuff_cnt=0, in_ready=0 in that cycle, bit_avali=0, bit_out=0. Clear has the same effect as rst and overrides all other inputs.
- in_ready = (fill ≤ BUF_W-16) & !clear & !eof_seen.
- Data path: buffer register, left-aligned. Valid bits are buf[BUF_W-1 -: fill]. bit_out = buf[BUF_W-1 -: 64]. Bits beyond fill read as 0.
- bit_avali = (fill ≥ 64) | (eof_seen & fill > 0 & !ff_pend). Combinational from registers.
- Consume: if eat_en & bit_avali, shift left by eat_num; fill -= min(eat_num, fill); bit_pos = (bit_pos + eat_num) mod 8. eat_en without bit_avali is ignored. eat_num > 64 is illegal; the bench asserts on it.
- Align: if align_req & bit_avali & !eat_en, discard (8-bit_pos) mod 8 bits; bit_pos becomes 0. align_req together with eat_en gives eat priority, and align is dropped. A pulse with bit_pos=0 is a no-op.
- Destuff (sub-module), per accepted byte:
  - destuff_en=0: append the byte; ff_pend is not used.
  - destuff_en=1, byte=0xFF, ff_pend=0: set ff_pend; append nothing.
  - ff_pend=1, byte=0x00: append 0xFF; stuff_cnt++; clear ff_pend.
  - ff_pend=1, byte≠0x00: append 0xFF then the byte (16 bits); set marker_seen; clear ff_pend.
  - ff_pend=1, byte=0xFF: append 0xFF; ff_pend stays 1.
- Fill update: fill_next = fill - eaten + appended. Append position is fill - eaten in the same cycle. Consume and append in one cycle must be exact.
- Latency: an accepted byte is visible in bit_out the next cycle.
- EOF: an accepted in_last byte sets eof_seen. If ff_pend is set at EOF, 0xFF is appended and ff_pend is cleared the next cycle. Afterwards no input is accepted and the tail drains with zero padding.
- Falling destuff_en with ff_pend=1: 0xFF is appended the next cycle; ff_pend clears.
- marker_seen clears only on rst or clear.

Decomposition:
- Shared define header: BUF_W default and the marker/stuff byte constants (0xFF, 0x00) next to the existing state defines.
- One sub-module: jpeg_destuff.
  - Inputs: byte, valid, destuff_en, eof.
  - Outputs: append_data[15:0], append_len (0/8/16), stuff_pulse, marker_pulse.
  - Owns ff_pend.
- Shift/fill logic stays in jpeg_bit_buffer.

Test Plan:
- Feed 8 bytes FF D8 FF DB 00 43 00 01, destuff_en=0 -> bit_avali rises the cycle after the 8th byte; bit_out=64'hFFD8FFDB00430001; stuff_cnt=0.
- destuff_en=1, feed 12 34 FF 00 56 78 9A BC DE -> bit_out=64'h1234FF56789ABCDE; stuff_cnt=1; marker_seen=0.
- Window 64'hA5A5..., eat_num=3 then align_req -> 5 more bits discarded; bit_pos=0; bit_out starts at the next byte.
- destuff_en=1, stream ... FF D9 (in_last on D9) -> marker_seen=1; bytes FF,D9 appended; tail drains with bit_avali while fill>0; zero-padded; in_ready=0.
- Keep in_valid=1 and eat 7 bits/cycle continuously -> fill never exceeds BUF_W; in_ready drops exactly when fill>112; no byte lost (compare against a model).
- Assert clear mid-stream with fill=90 and ff_pend=1 -> next cycle fill=0, bit_avali=0, marker_seen=0, stuff_cnt=0.
